// File: rtl/kaiser_pipe_pkg.sv
// Shared types and constants for the CPU pipeline stage registers.
package kaiser_pipe_pkg;

  localparam int unsigned CTRL_W = 22;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 16;

  typedef struct packed {
    logic [CTRL_W-1:0] control;
    logic [REG_W-1:0]  rm;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
  } pipe_payload_t;

  typedef enum logic [1:0] {EMPTY, MAIN, SKID} pipe_state_t;

  localparam pipe_payload_t PIPE_NOP  = '0;
  localparam int unsigned   PAYLOAD_W = $bits(pipe_payload_t);

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload-wide register: async active-low reset to NOP, synchronous clear beats enable.
module pipe_payload_reg
  import kaiser_pipe_pkg::*;
#(
  parameter int unsigned Width = PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_hs.sv
// Valid/ready pipeline stage register for the decoded-instruction payload.
// Define PIPE_SKID_EN for the two-entry build with a registered in_ready.
module pipeline_stage_hs #(
  parameter int unsigned CTRL_W = kaiser_pipe_pkg::CTRL_W,
  parameter int unsigned REG_W  = kaiser_pipe_pkg::REG_W,
  parameter int unsigned IMM_W  = kaiser_pipe_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [REG_W-1:0]  num_Rm_in,
  input  logic [REG_W-1:0]  num_Rn_in,
  input  logic [REG_W-1:0]  num_Rd_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  num_Rm_out,
  output logic [REG_W-1:0]  num_Rn_out,
  output logic [REG_W-1:0]  num_Rd_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [15:0]       stall_cnt
);
  import kaiser_pipe_pkg::*;

  // Widths must match the package payload struct.
  pipe_state_t   state_q, state_d;
  pipe_payload_t in_payload, main_q, main_d;
  logic          main_en, main_clr;
  logic          in_xfer, out_xfer;
  logic [15:0]   stall_q;

  always_comb begin
    in_payload         = PIPE_NOP;
    in_payload.control = control_in;
    in_payload.rm      = num_Rm_in;
    in_payload.rn      = num_Rn_in;
    in_payload.rd      = num_Rd_in;
    in_payload.imm     = imm_in;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready && !flush;
  assign out_xfer  = out_valid && out_ready && !flush;

`ifdef PIPE_SKID_EN
  pipe_payload_t skid_q;
  logic          skid_en, skid_clr;
  logic          in_ready_q;

  always_comb begin
    state_d  = state_q;
    main_d   = in_payload;
    main_en  = 1'b0;
    main_clr = flush;
    skid_en  = 1'b0;
    skid_clr = flush;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = MAIN;
          main_en = 1'b1;
        end
      end
      MAIN: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          state_d = SKID;
          skid_en = 1'b1;
        end else if (out_xfer) begin
          state_d  = EMPTY;
          main_clr = 1'b1;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_d  = MAIN;
          main_d   = skid_q;
          main_en  = 1'b1;
          skid_clr = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Registered ready breaks the out_ready -> in_ready combinational chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != SKID);
    end
  end

  assign in_ready = in_ready_q;

  pipe_payload_reg #(
    .Width(PAYLOAD_W)
  ) u_skid_reg (
    .clk(clk),
    .rst(rst),
    .en (skid_en),
    .clr(skid_clr),
    .d  (in_payload),
    .q  (skid_q)
  );
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d  = state_q;
    main_d   = in_payload;
    main_en  = 1'b0;
    main_clr = flush;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = MAIN;
          main_en = 1'b1;
        end
      end
      MAIN: begin
        // With the output held, an input transfer implies an output transfer.
        if (in_xfer) begin
          main_en = 1'b1;
        end else if (out_xfer) begin
          state_d  = EMPTY;
          main_clr = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  pipe_payload_reg #(
    .Width(PAYLOAD_W)
  ) u_main_reg (
    .clk(clk),
    .rst(rst),
    .en (main_en),
    .clr(main_clr),
    .d  (main_d),
    .q  (main_q)
  );

  assign control_out = main_q.control;
  assign num_Rm_out  = main_q.rm;
  assign num_Rn_out  = main_q.rn;
  assign num_Rd_out  = main_q.rd;
  assign imm_out     = main_q.imm;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// Scoreboard bench for pipeline_stage_hs; adapts expectations to PIPE_SKID_EN.
module tb_pipeline_stage_hs;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [21:0] control_in, control_out;
  logic [2:0]  num_Rm_in, num_Rn_in, num_Rd_in, num_Rm_out, num_Rn_out, num_Rd_out;
  logic [15:0] imm_in, imm_out, stall_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [46:0] sb[$];

  pipeline_stage_hs dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .control_in (control_in),
    .num_Rm_in  (num_Rm_in),
    .num_Rn_in  (num_Rn_in),
    .num_Rd_in  (num_Rd_in),
    .imm_in     (imm_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .control_out(control_out),
    .num_Rm_out (num_Rm_out),
    .num_Rn_out (num_Rn_out),
    .num_Rd_out (num_Rd_out),
    .imm_out    (imm_out),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload derived from the immediate so every field is exercised.
  function automatic logic [46:0] mk(input logic [15:0] imm);
    return {imm[5:0], imm, imm[2:0], imm[5:3], imm[8:6], imm};
  endfunction

  function automatic logic [46:0] out_word();
    return {control_out, num_Rm_out, num_Rn_out, num_Rd_out, imm_out};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] imm);
    in_valid = v;
    {control_in, num_Rm_in, num_Rn_in, num_Rd_in, imm_in} = mk(imm);
  endtask

  // One clock: record whether an input transfer happens, push its payload after the edge.
  task automatic tick();
    logic        acc;
    logic [46:0] cur;
    @(negedge clk);
    acc = in_valid && in_ready && !flush;
    cur = {control_in, num_Rm_in, num_Rn_in, num_Rd_in, imm_in};
    @(posedge clk);
    if (acc) sb.push_back(cur);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", out_word(), 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
  endtask

  // Monitor: pop and compare on every output transfer; bubbles must carry zeros.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_word(), 0);
        end else begin
          chk("out_payload", out_word(), sb.pop_front());
        end
      end else if (!out_valid) begin
        chk("bubble_zero", out_word(), 0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 16'h0);
    #3;
    check_reset_state();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 16'(i));
      #1;
      chk("stream_in_ready", in_ready, 1);
      if (i > 1) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_imm", imm_out, 64'(i - 1));
      end
      tick();
    end
    set_in(1'b0, 16'h0);
    #1;
    chk("stream_last_imm", imm_out, 16'h0008);
    tick();
    tick();
    chk("stream_drained", sb.size(), 0);
    chk("stream_stall", stall_cnt, 0);

    // Backpressure
    out_ready = 1'b0;
    set_in(1'b1, 16'hAAAA);
    #1;
    chk("bp_ready_a", in_ready, 1);
    tick();
    set_in(1'b1, 16'hBBBB);
    #1;
    chk("bp_imm_a", imm_out, 16'hAAAA);
`ifdef PIPE_SKID_EN
    chk("bp_ready_b", in_ready, 1);
    tick();
    set_in(1'b0, 16'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_full", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_imm_a2", imm_out, 16'hAAAA);
    tick();
    #1;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_imm_b", imm_out, 16'hBBBB);
    tick();
    #1;
    chk("bp_empty", out_valid, 0);
    chk("bp_stall", stall_cnt, 1);
`else
    chk("bp_ready_blocked", in_ready, 0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", in_ready, 1);
    tick();
    set_in(1'b0, 16'h0);
    out_ready = 1'b0;
    #1;
    chk("bp_ready_comb_lo", in_ready, 0);
    chk("bp_imm_b", imm_out, 16'hBBBB);
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb_hi", in_ready, 1);
    tick();
    #1;
    chk("bp_empty", out_valid, 0);
    chk("bp_stall", stall_cnt, 2);
`endif
    chk("bp_drained", sb.size(), 0);

    // Flush with the stage full
    out_ready = 1'b0;
    set_in(1'b1, 16'h1111);
    tick();
    set_in(1'b1, 16'h2222);
    tick();
    set_in(1'b1, 16'hCCCC);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    set_in(1'b0, 16'h0);
    sb.delete();
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_payload", out_word(), 0);
    chk("flush_in_ready_after", in_ready, 1);
`ifdef PIPE_SKID_EN
    chk("flush_stall_kept", stall_cnt, 2);
`else
    chk("flush_stall_kept", stall_cnt, 3);
`endif
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_cccc", out_valid, 0);

    // Reset mid-stream with payloads held
    out_ready = 1'b0;
    set_in(1'b1, 16'h3333);
    tick();
    set_in(1'b1, 16'h4444);
    tick();
    set_in(1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    set_in(1'b1, 16'h7777);
    tick();
    set_in(1'b0, 16'h0);
    #1;
    chk("post_rst_imm", imm_out, 16'h7777);
    tick();

    // Stall counter saturation
    out_ready = 1'b0;
    set_in(1'b1, 16'h5555);
    tick();
    set_in(1'b0, 16'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    chk("stall_hold_imm", imm_out, 16'h5555);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_sat_hold", stall_cnt, 16'hFFFF);
    out_ready = 1'b1;
    tick();
    tick();
    chk("final_drained", sb.size(), 0);
    chk("final_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_hs.md
# pipeline_stage_hs

Parametrised pipeline stage register carrying the decoded-instruction payload (control word, three register numbers, immediate) between adjacent CPU pipeline stages. Successor to the fixed-width enable-only stage registers: adds valid/ready handshake, flush-to-bubble and an optional skid entry so that backpressure does not form a combinational path through the pipeline. It sits between decode and register-read, and is reused at every later stage boundary.

## Interface
- CTRL_W, 22: control word width
- REG_W, 3: register-number width (Rm, Rn, Rd)
- IMM_W, 16: immediate width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream holds a valid payload
- in_ready  out  1  stage can accept a payload this cycle
- control_in / num_Rm_in / num_Rn_in / num_Rd_in / imm_in  in  CTRL_W / REG_W / REG_W / REG_W / IMM_W  incoming payload
- flush  in  1  kill all held payloads (branch/exception)
- out_valid  out  1  control_out..imm_out hold a valid payload
- out_ready  in  1  downstream accepts the payload this cycle
- control_out / num_Rm_out / num_Rn_out / num_Rd_out / imm_out  out  same widths  registered payload
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready at edge. Transfer out: out_valid && out_ready at edge.
- Payload outputs always driven from a register (never from inputs).
- Reset (rst=0, any time, mid-transfer included): out_valid=0, all payload outputs 0 (control=0 is NOP), stall_cnt=0, in_ready=1, state EMPTY.
- flush=1: at next edge all entries invalid, payload outputs 0, state EMPTY; in_valid that cycle ignored (no transfer in, regardless of in_ready). Flush overrides out_ready; no output transfer counted. stall_cnt not cleared by flush.
- Invalid payload: when out_valid=0, payload outputs are 0.
- stall_cnt increments by 1 when out_valid && !out_ready and no flush; holds at 16'hFFFF.
- States (skid build): EMPTY (0 held), MAIN (output reg full, skid empty), SKID (both full).
  - EMPTY: in xfer -> MAIN.
  - MAIN: in xfer && out xfer -> MAIN (new payload to output); in xfer && !out_ready -> SKID (new payload to skid); out xfer only -> EMPTY.
  - SKID: out xfer -> MAIN (skid moves to output, skid cleared); else stay. No in xfer possible.
- Order preserved: payloads leave in acceptance order; none duplicated or dropped except by flush/reset.

## Timing
- Latency: payload accepted at edge N appears on outputs after edge N (visible cycle N+1) when stage was EMPTY or draining.
- Throughput: one payload per cycle while out_ready=1.
- Skid build: in_ready is a register output = (state != SKID) next-state; no combinational path out_ready -> in_ready.
- Non-skid build: in_ready = !out_valid || out_ready (combinational); flush does not gate in_ready.
- out_valid, payload and stall_cnt change only on clk edge or asynchronous rst assertion.

## Configuration
- PIPE_SKID_EN defined: two-entry implementation with SKID state and registered in_ready as above.
- PIPE_SKID_EN undefined: single entry, states EMPTY/MAIN only, combinational in_ready; all other behaviour (flush, reset values, stall_cnt, latency) identical.

## Structure
- Shared package kaiser_pipe_pkg: typedef struct packed pipe_payload_t (control, Rm, Rn, Rd, imm) parametrised via package constants CTRL_W=22, REG_W=3, IMM_W=16; enum pipe_state_t {EMPTY, MAIN, SKID}; constant PIPE_NOP = '0.
- One sub-module: pipe_payload_reg — payload-wide register with enable, synchronous clear (flush) and async active-low reset to 0; instantiated once for the output entry and once for the skid entry.

## Test plan
- Reset mid-stream: hold out_ready=0 with two payloads held, drop rst -> out_valid=0, all payload outputs 0, in_ready=1, stall_cnt=0 immediately.
- Streaming: out_ready=1, in_valid=1 with imm 16'h0001..0x0008 on consecutive cycles -> outputs 0x0001..0x0008 one cycle later, no gaps, stall_cnt=0.
- Backpressure (skid): accept imm=0xAAAA, then 0xBBBB with out_ready=0 -> in_ready=0 after second edge; release out_ready -> 0xAAAA then 0xBBBB out, in_ready=1 one cycle after first out transfer.
- Flush with full stage: SKID state, flush=1 and in_valid=1 with imm=0xCCCC -> next cycle out_valid=0, payload 0, in_ready=1; 0xCCCC never appears.
- Stall counter: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, holds.
- Non-skid build: same backpressure sequence -> in_ready tracks out_ready combinationally while out_valid=1; order 0xAAAA, 0xBBBB preserved.
